// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one memory read channel between I-cache and D-cache refills.
// Latency: request to m_arvalid 1 cycle; memory beats reach the owner combinationally.
// Backpressure: loser holds arvalid until the current burst ends; owner's rready drives m_rready.
module mem_read_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [LEN_WIDTH-1:0]  i_arlen,
  input  logic                  i_arvalid,
  output logic                  i_arready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_rvalid,
  input  logic                  i_rready,
  input  logic [ADDR_WIDTH-1:0] d_araddr,
  input  logic [LEN_WIDTH-1:0]  d_arlen,
  input  logic                  d_arvalid,
  output logic                  d_arready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rvalid,
  input  logic                  d_rready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [LEN_WIDTH-1:0]  m_arlen,
  output logic [3:0]            m_arid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  grant_d,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state;
  logic                 rr_last;   // last winner: 0 = I, 1 = D
  logic [LEN_WIDTH-1:0] cnt;       // beats still to transfer in DATA
  logic                 pick_d;
  logic                 idle_ok;
  logic                 in_data;
  logic                 beat_fire;

  // D wins when it is the only requester, or on a tie when I won last time.
  always_comb begin
    pick_d = d_arvalid & (~i_arvalid | ~rr_last);
  end

  // arready depends only on state and arvalid inputs; gated by rst_n so it is low during reset.
  assign idle_ok   = rst_n & (state == IDLE);
  assign i_arready = idle_ok & i_arvalid & ~pick_d;
  assign d_arready = idle_ok & pick_d;

  assign in_data   = (state == DATA);
  assign m_arvalid = (state == ADDR);
  assign m_rready  = in_data & (grant_d ? d_rready : i_rready);
  assign i_rvalid  = in_data & ~grant_d & m_rvalid;
  assign d_rvalid  = in_data &  grant_d & m_rvalid;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign busy      = (state != IDLE);
  assign beat_fire = m_rvalid & m_rready;

  // Burst sequencer: grant in IDLE, hold the address phase in ADDR, count beats in DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      cnt      <= '0;
      grant_d  <= 1'b0;
      m_araddr <= '0;
      m_arlen  <= '0;
      m_arid   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_arvalid | d_arvalid) begin
            grant_d  <= pick_d;
            rr_last  <= pick_d;
            m_araddr <= pick_d ? d_araddr : i_araddr;
            m_arlen  <= pick_d ? d_arlen : i_arlen;
            m_arid   <= {3'b000, pick_d};
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            // A zero length still moves one beat.
            cnt   <= (m_arlen == '0) ? LEN_WIDTH'(1) : m_arlen;
            state <= DATA;
          end
        end
        DATA: begin
          if (beat_fire) begin
            if (cnt == LEN_WIDTH'(1)) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt - LEN_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: directed bursts, memory responder, decoupled monitor.
// Expected address phases and beats are queued when stimulus is issued.
// Cache rready patterns and a one-cycle arready delay provide backpressure.
module tb_mem_read_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] i_araddr = '0, d_araddr = '0;
  logic [LW-1:0] i_arlen = '0, d_arlen = '0;
  logic          i_arvalid = 1'b0, d_arvalid = 1'b0;
  logic          i_arready, d_arready;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_rvalid, d_rvalid;
  logic          i_rready = 1'b1, d_rready = 1'b1;
  logic [AW-1:0] m_araddr;
  logic [LW-1:0] m_arlen;
  logic [3:0]    m_arid;
  logic          m_arvalid;
  logic          m_arready = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_rvalid = 1'b0;
  logic          m_rready;
  logic          grant_d, busy;

  always #5 clk = ~clk;

  mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant_d(grant_d), .busy(busy)
  );

  typedef struct packed {logic [AW-1:0] addr; logic [LW-1:0] len;} req_t;
  typedef struct packed {logic [AW-1:0] addr; logic [LW-1:0] len; logic [3:0] id;} ar_t;
  typedef struct packed {logic d; logic [DW-1:0] data; logic last;} beat_t;

  req_t          i_req_q[$], d_req_q[$];
  ar_t           ar_q[$];
  beat_t         beat_q[$];
  logic [DW-1:0] mem_q[$];

  int checks = 0;
  int errors = 0;
  int beats_done = 0;

  // values sampled on the falling edge, consumed by the driver after the next rising edge
  logic ar_fire_s = 0, r_fire_s = 0, arv_s = 0, i_hs = 0, d_hs = 0;
  logic [LW-1:0] len_s = '0;
  logic exp_arv = 0, pend_idle = 0;
  logic [3:0] i_pat = 4'b1111, d_pat = 4'b1111;
  int ph = 0;
  int r_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue one burst in expected grant order: request, address phase, memory data, routed beats.
  task automatic burst(input logic d, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                       input logic [DW-1:0] base);
    req_t  r;
    ar_t   a;
    beat_t b;
    int    n;
    n = (len == 0) ? 1 : int'(len);
    r.addr = addr; r.len = len;
    if (d) d_req_q.push_back(r); else i_req_q.push_back(r);
    a.addr = addr; a.len = len; a.id = {3'b000, d};
    ar_q.push_back(a);
    for (int j = 0; j < n; j++) begin
      mem_q.push_back(base + DW'(j));
      b.d = d; b.data = base + DW'(j); b.last = (j == n - 1);
      beat_q.push_back(b);
    end
  endtask

  task automatic take_beat(input logic d, input logic [DW-1:0] data);
    beat_t b;
    if (beat_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_beat: got owner %0d data %0h, expected none", d, data);
    end else begin
      b = beat_q.pop_front();
      chk("beat_owner", 64'(d), 64'(b.d));
      chk("beat_data", 64'(data), 64'(b.data));
      if (b.last) pend_idle = 1'b1;
    end
    beats_done++;
  endtask

  function automatic logic [DW-1:0] next_mem();
    if (mem_q.size() == 0) return 32'hDEADBEEF;
    return mem_q.pop_front();
  endfunction

  // Monitor: samples on the falling edge and pops expectations whenever the DUT presents output.
  initial begin
    ar_t a;
    forever begin
      @(negedge clk);
      ar_fire_s = m_arvalid & m_arready;
      r_fire_s  = m_rvalid & m_rready;
      arv_s     = m_arvalid;
      len_s     = m_arlen;
      i_hs      = i_arvalid & i_arready;
      d_hs      = d_arvalid & d_arready;
      if (!rst_n) begin
        exp_arv = 0; pend_idle = 0;
      end else begin
        if (exp_arv) chk("ar_latency", 64'(m_arvalid), 64'd1);
        exp_arv = i_hs | d_hs;
        if (pend_idle) begin
          chk("idle_after_last", 64'(busy), 64'd0);
          if (i_arvalid | d_arvalid) chk("regrant_in_idle", 64'(i_arready | d_arready), 64'd1);
          pend_idle = 0;
        end
        if (ar_fire_s) begin
          if (ar_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ar: got addr %0h id %0h, expected none", m_araddr, m_arid);
          end else begin
            a = ar_q.pop_front();
            chk("m_araddr", 64'(m_araddr), 64'(a.addr));
            chk("m_arlen", 64'(m_arlen), 64'(a.len));
            chk("m_arid", 64'(m_arid), 64'(a.id));
            chk("grant_d", 64'(grant_d), 64'(a.id[0]));
          end
        end
        if (m_rvalid && busy) begin
          chk("m_rready_mirror", 64'(m_rready), 64'(grant_d ? d_rready : i_rready));
          chk("rvalid_route", 64'({i_rvalid, d_rvalid}), grant_d ? 64'd1 : 64'd2);
        end
        if (i_rvalid && i_rready) take_beat(1'b0, i_rdata);
        if (d_rvalid && d_rready) take_beat(1'b1, d_rdata);
      end
    end
  end

  // Driver: caches and memory responder, updated just after each rising edge.
  initial begin
    req_t r;
    forever begin
      @(posedge clk);
      #1;
      if (i_hs) i_arvalid = 1'b0;
      if (!i_arvalid && i_req_q.size() > 0) begin
        r = i_req_q.pop_front(); i_araddr = r.addr; i_arlen = r.len; i_arvalid = 1'b1;
      end
      if (d_hs) d_arvalid = 1'b0;
      if (!d_arvalid && d_req_q.size() > 0) begin
        r = d_req_q.pop_front(); d_araddr = r.addr; d_arlen = r.len; d_arvalid = 1'b1;
      end
      i_rready = i_pat[ph];
      d_rready = d_pat[ph];
      ph = (ph + 1) % 4;
      if (!rst_n) begin
        m_arready = 1'b0; m_rvalid = 1'b0; r_left = 0;
      end else begin
        if (ar_fire_s) begin
          m_arready = 1'b0;
          r_left = (len_s == 0) ? 1 : int'(len_s);
          m_rvalid = 1'b1;
          m_rdata = next_mem();
        end else if (arv_s && !m_arready) begin
          m_arready = 1'b1;
        end
        if (r_fire_s) begin
          r_left--;
          if (r_left <= 0) m_rvalid = 1'b0;
          else m_rdata = next_mem();
        end
      end
    end
  end

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      done = (ar_q.size() == 0) && (beat_q.size() == 0) && (i_req_q.size() == 0) &&
             (d_req_q.size() == 0) && !i_arvalid && !d_arvalid && !busy && !m_rvalid;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  initial begin
    logic ok;
    // I-only burst; request is already presented while reset is held
    burst(1'b0, 26'h0001240, 5'd4, 32'hA0);
    @(posedge clk); #3;
    chk("rst_i_arready", 64'(i_arready), 64'd0);
    chk("rst_d_arready", 64'(d_arready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_m_rready", 64'(m_rready), 64'd0);
    chk("rst_grant_d", 64'(grant_d), 64'd0);
    chk("rst_m_araddr", 64'(m_araddr), 64'd0);
    chk("rst_m_arlen", 64'(m_arlen), 64'd0);
    chk("rst_m_arid", 64'(m_arid), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("i_only_arready", 64'(i_arready), 64'd1);
    chk("i_only_d_arready", 64'(d_arready), 64'd0);
    drain("drain_i_only");

    // Simultaneous requests after reset: I first, then D
    pulse_reset();
    burst(1'b0, 26'h0002000, 5'd4, 32'hB0);
    burst(1'b1, 26'h0003000, 5'd4, 32'hC0);
    drain("drain_simultaneous");

    // Round-robin with both requesters continuously valid
    for (int k = 0; k < 3; k++) begin
      burst(1'b0, AW'(26'h100 * (2 * k + 1)), 5'd2, DW'(32'h1000 * (2 * k + 1)));
      burst(1'b1, AW'(26'h100 * (2 * k + 2)), 5'd2, DW'(32'h1000 * (2 * k + 2)));
    end
    drain("drain_round_robin");

    // D burst under rready backpressure 1,0,0,1
    d_pat = 4'b1001;
    burst(1'b1, 26'h0000500, 5'd4, 32'hD0);
    drain("drain_backpressure");
    d_pat = 4'b1111;

    // Length corners: 0 behaves as 1 beat, 16 is a full burst
    burst(1'b1, 26'h0000600, 5'd0, 32'hE0);
    drain("drain_len0");
    burst(1'b1, 26'h0000700, 5'd16, 32'hF00);
    drain("drain_len16");

    // Reset during beat 2 of 4
    begin
      int target;
      target = beats_done + 1;
      burst(1'b0, 26'h0000900, 5'd4, 32'h90);
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        ok = (beats_done >= target);
      end
      chk("midburst_first_beat", 64'(ok), 64'd1);
    end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_i_rvalid", 64'(i_rvalid), 64'd0);
    chk("async_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("async_m_rready", 64'(m_rready), 64'd0);
    chk("async_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("async_grant_d", 64'(grant_d), 64'd0);
    chk("async_m_araddr", 64'(m_araddr), 64'd0);
    beat_q.delete();
    mem_q.delete();
    burst(1'b0, 26'h0000800, 5'd1, 32'h80);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("arready_after_reset", 64'(i_arready), 64'd1);
    drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
